udp_header_rx: RTL

UDP_HEADER_RX -- requirements
Module: udp_header_rx

---
 rtl/udp_pkg.sv | 15 +
 rtl/udp_header_rx.sv | 123 ++++++++++++
 2 files changed

// File: rtl/udp_pkg.sv
// Shared UDP definitions: header length and the receive/transmit state set.
package udp_pkg;

   localparam int UDP_HDR_LEN = 8;

   typedef enum logic [2:0] {
      WAIT_START,
      PORT_SOURCE_RX,
      PORT_DESTINATION_RX,
      LENGTH_RX,
      CHECKSUM_RX,
      PAYLOAD_RX
   } udp_state_t;

endpackage

// File: rtl/udp_header_rx.sv
// UDP header parser: captures the four 16-bit header fields after the IP header
// and forwards the payload of frames addressed to local_port.
module udp_header_rx
   import udp_pkg::*;
(
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        ip_header_rx_done,
   input  logic [7:0]  data_in,
   input  logic        data_in_valid,
   input  logic [15:0] local_port,
   output logic [15:0] port_s,
   output logic [15:0] port_d,
   output logic [15:0] udp_len_field,
   output logic [15:0] checksum,
   output logic        udp_header_rx_done,
   output logic        port_match,
   output logic        len_err,
   output logic [7:0]  payload_data,
   output logic        payload_valid,
   output logic        payload_last
);

   udp_state_t  state;
   logic        byte_cnt;
   logic [15:0] payload_cnt;
   logic        port_hit;
   logic        len_short;
   logic        payload_ok;

   // Evaluated while the last checksum byte arrives; port_d and the length are complete by then.
   always_comb begin
      port_hit   = (port_d == local_port);
      len_short  = (udp_len_field < 16'(UDP_HDR_LEN));
      payload_ok = port_hit && !len_short && (udp_len_field > 16'(UDP_HDR_LEN));
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state              <= WAIT_START;
         byte_cnt           <= 1'b0;
         payload_cnt        <= '0;
         port_s             <= '0;
         port_d             <= '0;
         udp_len_field      <= '0;
         checksum           <= '0;
         udp_header_rx_done <= 1'b0;
         port_match         <= 1'b0;
         len_err            <= 1'b0;
         payload_data       <= '0;
         payload_valid      <= 1'b0;
         payload_last       <= 1'b0;
      end else begin
         udp_header_rx_done <= 1'b0;
         payload_valid      <= 1'b0;
         payload_last       <= 1'b0;
         payload_data       <= '0;
         case (state)
            WAIT_START: begin
               if (ip_header_rx_done) begin
                  state    <= PORT_SOURCE_RX;
                  byte_cnt <= 1'b0;
               end
            end
            PORT_SOURCE_RX: begin
               if (data_in_valid) begin
                  if (!byte_cnt) port_s[15:8] <= data_in;
                  else           port_s[7:0]  <= data_in;
                  byte_cnt <= ~byte_cnt;
                  if (byte_cnt) state <= PORT_DESTINATION_RX;
               end
            end
            PORT_DESTINATION_RX: begin
               if (data_in_valid) begin
                  if (!byte_cnt) port_d[15:8] <= data_in;
                  else           port_d[7:0]  <= data_in;
                  byte_cnt <= ~byte_cnt;
                  if (byte_cnt) state <= LENGTH_RX;
               end
            end
            LENGTH_RX: begin
               if (data_in_valid) begin
                  if (!byte_cnt) udp_len_field[15:8] <= data_in;
                  else           udp_len_field[7:0]  <= data_in;
                  byte_cnt <= ~byte_cnt;
                  if (byte_cnt) state <= CHECKSUM_RX;
               end
            end
            CHECKSUM_RX: begin
               if (data_in_valid) begin
                  if (!byte_cnt) checksum[15:8] <= data_in;
                  else           checksum[7:0]  <= data_in;
                  byte_cnt <= ~byte_cnt;
                  if (byte_cnt) begin
                     udp_header_rx_done <= 1'b1;
                     port_match         <= port_hit;
                     len_err            <= len_short;
                     if (payload_ok) begin
                        state       <= PAYLOAD_RX;
                        payload_cnt <= udp_len_field - 16'(UDP_HDR_LEN);
                     end else begin
                        state <= WAIT_START;
                     end
                  end
               end
            end
            PAYLOAD_RX: begin
               if (data_in_valid) begin
                  payload_valid <= 1'b1;
                  payload_data  <= data_in;
                  payload_cnt   <= payload_cnt - 16'd1;
                  if (payload_cnt == 16'd1) begin
                     payload_last <= 1'b1;
                     state        <= WAIT_START;
                  end
               end
            end
            default: state <= WAIT_START;
         endcase
      end
   end

endmodule
